// File: rtl/mult_div_unit_pkg.sv
// ---------------------------------------------------------------
// mdu_pkg : state and op-code constants for the multiply/divide unit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------
// mult_div_unit_if : request/result bundle between controller and MDU
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op, operand_a, operand_b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit_counter.sv
// ---------------------------------------------------------------
// mdu_counter : iteration counter with clear/enable and last flag
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mdu_counter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------
// mult_div_unit : iterative unsigned multiply (shift-add) / divide (restoring)
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   dvs;
  logic               op_q;
  logic [CW-1:0]      count;
  logic               last;
  logic               accept;
  logic               div_zero_req;
  logic [WIDTH:0]     add_a;
  logic [WIDTH:0]     add_b;
  logic [WIDTH:0]     sum;
  logic               neg;

  assign accept       = (state == S_IDLE) && bus.start;
  assign div_zero_req = (bus.op == OP_DIV) && (bus.operand_b == '0);

  mdu_counter #(.WIDTH(WIDTH), .CW(CW)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .en    (state == S_RUN),
    .count (count),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = div_zero_req ? S_DONE : S_RUN;
      S_RUN:   if (last) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != S_IDLE);
    bus.done = (state == S_DONE);
  end

  // Shared adder: MUL adds into the upper half; DIV trial-subtracts from
  // the left-shifted remainder, whose top bit can exceed WIDTH bits.
  always_comb begin
    add_a = (op_q == OP_DIV) ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
    add_b = {1'b0, dvs};
    sum   = (op_q == OP_DIV) ? (add_a - add_b) : (add_a + add_b);
    neg   = (op_q == OP_DIV) && !add_a[WIDTH] && sum[WIDTH];
    if (op_q == OP_DIV) begin
      acc_step = neg ? {acc[2*WIDTH-2:0], 1'b0}
                     : {sum[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = acc[0] ? {sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc             <= '0;
      dvs             <= '0;
      op_q            <= OP_MUL;
      bus.hi          <= '0;
      bus.lo          <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        acc  <= {{WIDTH{1'b0}}, bus.operand_a};
        dvs  <= bus.operand_b;
        op_q <= bus.op;
        if (div_zero_req) begin
          bus.hi          <= bus.operand_a;
          bus.lo          <= '1;
          bus.div_by_zero <= 1'b1;
        end
      end else if (state == S_RUN) begin
        acc <= acc_step;
        if (last) begin
          bus.hi          <= acc_step[2*WIDTH-1:WIDTH];
          bus.lo          <= acc_step[WIDTH-1:0];
          bus.div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------
// tb_mult_div_unit : directed vectors with a queue-based result scoreboard
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_mult_div_unit;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dbz;
    int         exp_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  mult_div_unit_if #(.WIDTH(8)) bus ();

  mult_div_unit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      check("done_width", int'(prev_done), 0);
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("hi", int'(bus.hi), int'(e.hi));
        check("lo", int'(bus.lo), int'(e.lo));
        check("div_by_zero", int'(bus.div_by_zero), int'(e.dbz));
        if (e.exp_cyc >= 0) check("latency", cyc, e.exp_cyc);
      end
    end
    prev_done = bus.done;
  end

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      check("timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eh, input logic [7:0] el, input logic ed,
                       input logic chk_lat);
    int   k;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b0;
    bus.operand_a = 8'($urandom);
    bus.operand_b = 8'($urandom);
    check("busy_after_start", int'(bus.busy), 1);
    e.hi = eh; e.lo = el; e.dbz = ed;
    e.exp_cyc = chk_lat ? k + 8 : -1;
    sb.push_back(e);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   k;
    exp_t e;
    bus.start = 1'b0; bus.op = 1'b0; bus.operand_a = '0; bus.operand_b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_hi", int'(bus.hi), 0);
    check("rst_lo", int'(bus.lo), 0);
    check("rst_dbz", int'(bus.div_by_zero), 0);
    rst = 1'b0;

    issue(1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 1'b1);
    issue(1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 1'b1);
    issue(1'b0, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, 1'b1);
    issue(1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 1'b1);
    issue(1'b1, 8'd5,   8'd9,   8'h05, 8'h00, 1'b0, 1'b1);
    issue(1'b1, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 1'b1);
    issue(1'b1, 8'h55,  8'd0,   8'h55, 8'hFF, 1'b1, 1'b0);
    issue(1'b0, 8'h80,  8'd2,   8'h01, 8'h00, 1'b0, 1'b1);

    // Abort an in-flight MUL with reset; a start during RUN is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 8'd3; bus.operand_b = 8'd4;
    @(posedge clk);
    #1;
    k = cyc;
    bus.start = 1'b0;
    while (cyc < k + 2) @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b1; bus.operand_a = 8'd9; bus.operand_b = 8'd3;
    while (cyc < k + 3) @(negedge clk);
    bus.start = 1'b0;
    check("busy_mid_run", int'(bus.busy), 1);
    while (cyc < k + 4) @(negedge clk);
    rst = 1'b1;
    while (cyc < k + 5) @(negedge clk);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_hi", int'(bus.hi), 0);
    check("abort_lo", int'(bus.lo), 0);
    rst = 1'b0;
    issue(1'b1, 8'd9, 8'd3, 8'h00, 8'h03, 1'b0, 1'b1);

    // start held high: second op accepted in the IDLE cycle after DONE
    @(negedge clk);
    bus.start = 1'b1; bus.op = 1'b0; bus.operand_a = 8'd2; bus.operand_b = 8'd3;
    @(posedge clk);
    #1;
    k = cyc;
    e.hi = 8'h00; e.lo = 8'h06; e.dbz = 1'b0;
    e.exp_cyc = k + 8;
    sb.push_back(e);
    e.exp_cyc = k + 18;
    sb.push_back(e);
    while (cyc < k + 9) @(negedge clk);
    check("b2b_idle_busy", int'(bus.busy), 0);
    check("b2b_hold_hi", int'(bus.hi), 0);
    check("b2b_hold_lo", int'(bus.lo), 6);
    while (cyc < k + 10) @(negedge clk);
    bus.start = 1'b0;
    check("b2b_second_accept", int'(bus.busy), 1);
    while (cyc < k + 12) @(negedge clk);
    check("b2b_run_hold_lo", int'(bus.lo), 6);
    drain();
    repeat (2) @(negedge clk);
    check("post_hold_lo", int'(bus.lo), 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
